// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with a parallel load, and two set buttons that auto-repeat while held.
// The count always stays within [MIN_VALUE, MIN_VALUE+MODULUS-1].
module mod_n_updown_counter #(
  parameter int WIDTH        = 3,
  parameter int MODULUS      = 6,
  parameter int MIN_VALUE    = 0,
  parameter int RESET_VALUE  = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adj_up,
  input  logic             adj_dn,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  // state  | meaning
  // IDLE   | no button held (or both held)
  // HOLD   | first step taken, waiting REPEAT_DELAY cycles
  // REPEAT | auto-stepping every REPEAT_RATE cycles
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} adj_state_t;

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MIN_VALUE + MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] DELAY_TC = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_TC  = TW'(REPEAT_RATE - 1);

  adj_state_t       state;
  logic [TW-1:0]    timer;
  logic             dir_q;
  logic             held, hdir, adj_active, flip, adj_step, load_ok;
  logic             at_max, at_min;
  logic [31:0]      load_off;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;

  always_comb begin
    held       = adj_up ^ adj_dn;
    hdir       = adj_dn;
    adj_active = adj_up | adj_dn;
    flip       = held && (state != IDLE) && (hdir != dir_q);
    at_max     = (count == MAX_V);
    at_min     = (count == MIN_V);
    cnt_inc    = at_max ? MIN_V : count + WIDTH'(1);
    cnt_dec    = at_min ? MAX_V : count - WIDTH'(1);
    // Unsigned offset wraps negative values high, so one compare covers both bounds.
    load_off   = 32'(load_val) - 32'(MIN_VALUE);
    load_ok    = (load_off < 32'(MODULUS));
    adj_step   = 1'b0;
    case (state)
      IDLE:    adj_step = held;
      HOLD:    adj_step = held && (flip || timer == DELAY_TC);
      REPEAT:  adj_step = held && (flip || timer == RATE_TC);
      default: adj_step = 1'b0;
    endcase
  end

  // The FSM advances on adj_step even when a load overrides the count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      dir_q <= 1'b0;
    end else if (!held) begin
      state <= IDLE;
      timer <= '0;
    end else if (state == IDLE || flip) begin
      state <= HOLD;
      timer <= '0;
      dir_q <= hdir;
    end else if (adj_step) begin
      state <= REPEAT;
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= RST_V;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) count <= load_val;
        else         load_err <= 1'b1;
      end else if (adj_step) begin
        count <= hdir ? cnt_dec : cnt_inc;
      end else if (!adj_active && en) begin
        if (dec) begin
          count  <= cnt_dec;
          borrow <= at_min;
        end else begin
          count <= cnt_inc;
          carry <= at_max;
        end
      end
    end
  end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3: count register width in bits.
REQ-002 Parameter MODULUS, default 6: number of distinct count values.
REQ-003 Parameter MIN_VALUE, default 0: lowest count value; MAX_VALUE = MIN_VALUE+MODULUS-1.
REQ-004 Parameter RESET_VALUE, default 0: count after reset; must lie in [MIN_VALUE, MAX_VALUE].
REQ-005 Parameter REPEAT_DELAY, default 8: clk cycles from first adjust step to first auto-repeat step.
REQ-006 Parameter REPEAT_RATE, default 2: clk cycles between auto-repeat steps.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 en  in  1  count-enable tick; one step per cycle asserted.
REQ-010 dec  in  1  direction for en steps: 0 up, 1 down.
REQ-011 load  in  1  synchronous parallel load strobe.
REQ-012 load_val  in  WIDTH  value for load.
REQ-013 adj_up  in  1  held set-button, step up, synchronous and debounced.
REQ-014 adj_dn  in  1  held set-button, step down, synchronous and debounced.
REQ-015 count  out  WIDTH  current value, registered.
REQ-016 carry  out  1  one-cycle pulse: en-driven wrap MAX_VALUE->MIN_VALUE.
REQ-017 borrow  out  1  one-cycle pulse: en-driven wrap MIN_VALUE->MAX_VALUE.
REQ-018 load_err  out  1  one-cycle pulse: load rejected as out of range.

Function
REQ-019 Per-cycle priority: load > adjust step > en step; a lower-priority source is ignored in any cycle a higher one is active (adj_up or adj_dn asserted counts as active).
REQ-020 Load with load_val in [MIN_VALUE, MAX_VALUE]: count = load_val next cycle; otherwise count unchanged and load_err = 1 next cycle.
REQ-021 Up step: MAX_VALUE -> MIN_VALUE, else +1; down step: MIN_VALUE -> MAX_VALUE, else -1; count never leaves range.
REQ-022 carry/borrow assert only for en-driven wraps, in the cycle count shows the wrapped value; adjust and load wraps never pulse them.
REQ-023 Adjust FSM states IDLE, HOLD, REPEAT; internal cycle timer sized for max(REPEAT_DELAY, REPEAT_RATE).
REQ-024 Exactly one of adj_up/adj_dn asserted is "held"; neither or both is "released".
REQ-025 IDLE + held: step once in held direction, timer = 0, go HOLD.
REQ-026 HOLD: timer increments; at timer = REPEAT_DELAY-1 step, timer = 0, go REPEAT.
REQ-027 REPEAT: timer increments; at timer = REPEAT_RATE-1 step, timer = 0, stay REPEAT.
REQ-028 Release in HOLD or REPEAT: go IDLE, timer = 0, no step that cycle.
REQ-029 Held direction flips (adj_up<->adj_dn without a released cycle): step immediately in new direction, timer = 0, go HOLD.
REQ-030 Load while adjust held: load wins that cycle, no step; FSM state and timer advance as if a step had occurred.
REQ-031 All outputs registered; count changes one cycle after the qualifying input edge.

Reset
REQ-032 rst asserted: immediately count = RESET_VALUE, carry = borrow = load_err = 0, FSM = IDLE, timer = 0, independent of clk.
REQ-033 rst mid-repeat: after deassertion a still-held button is treated as a new press (IDLE rule).

Verification
REQ-034 Defaults (WIDTH 3, MODULUS 6, MIN 0, DELAY 8, RATE 2): en=1 dec=0 from 0 for 7 cycles -> count 1,2,3,4,5,0,1; carry high only with count 0.
REQ-035 MIN_VALUE=1, MODULUS=12, WIDTH=4, count=1: en=1 dec=1 one cycle -> count 12, borrow 1.
REQ-036 Defaults, count 5: hold adj_up 20 cycles -> steps at cycles 0, 8, 10, 12, 14, 16, 18, count wraps 5->0->1..., carry never asserted, en ignored throughout.
REQ-037 load_val=7 (defaults) -> count unchanged, load_err 1 for one cycle; load_val=3 -> count 3, load_err 0.
REQ-038 adj_up and adj_dn asserted together with en=1 -> count unchanged, FSM IDLE.
REQ-039 rst pulsed between clk edges during REPEAT -> count = RESET_VALUE immediately, next held cycle steps once then waits REPEAT_DELAY.
